// File: rtl/instr_encoder_loader_if.sv
// Request, instruction-memory and status signals of instr_encoder_loader.
// The master modport is the requester/memory side and the slave modport is the encoder.
interface instr_encoder_loader_if #(
  parameter int unsigned CNT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              base_load;
  logic [31:0]       base_addr;
  logic              imem_we;
  logic [31:0]       imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;
  logic              err_kind;
  logic [CNT_W-1:0]  word_count;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    output base_load, base_addr, imem_ack,
    input  in_ready, imem_we, imem_addr, imem_wdata, err_kind, word_count
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    input  base_load, base_addr, imem_ack,
    output in_ready, imem_we, imem_addr, imem_wdata, err_kind, word_count
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Encodes MIPS-style R/I/J instructions and writes them to sequential words of
// instruction memory through a valid/ack write port.
module instr_encoder_loader #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_encoder_loader_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       enc;
  logic              supported;

  always_comb begin
    enc       = 32'h0;
    supported = 1'b1;
    case (bus.in_kind)
      3'd0:    enc = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, 5'b00000, bus.in_funct};
      3'd1:    enc = {6'b001000, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd2:    enc = {6'b100011, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd3:    enc = {6'b101011, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd4:    enc = {6'b000100, bus.in_rs, bus.in_rt, bus.in_imm};
      3'd5:    enc = {6'b000010, bus.in_target};
      default: supported = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A coincident base load retargets the word being accepted on this edge.
        if (bus.base_load) addr_d = {bus.base_addr[31:2], 2'b00};
        if (bus.in_valid) begin
          if (supported) begin
            wdata_d = enc;
            state_d = StWrite;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (bus.imem_ack) begin
          state_d = StIdle;
          addr_d  = addr_q + 32'd4;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= RESET_ADDR;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.imem_we    = (state_q == StWrite);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.err_kind   = err_q;
  assign bus.word_count = cnt_q;

endmodule
